// File: rtl/stream_demux_pkg.sv
// ============================================================================
// stream_demux_pkg
// Shared constants, select-width helper and channel-vector types for the
// stream demultiplexer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package stream_demux_pkg;

  localparam int DROP_CNT_W = 8;
  localparam int MAX_CH     = 16;
  localparam int MAX_SW     = 4;

  // Per-channel flag bus padded to the largest supported channel count.
  typedef logic [MAX_CH-1:0]     ch_vec_t;
  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// demux_slot
// One-entry holding register (full flag + data) for a single output channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // A load in the same cycle as a drain keeps the slot full: no bubble.
  always_comb begin
    full_d = load_i | (full_q & ~ready_i);
    data_d = load_i ? data_i : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// ============================================================================
// stream_demux
// Routes each accepted upstream beat to one of N_CH per-channel slots, chosen
// by up_sel or by an internal rotating TDM counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 8,
  parameter int AUTO_SEL = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [W-1:0]            up_data,
  input  logic [sel_w(N_CH)-1:0]  up_sel,
  input  logic                    resync,
  output logic [N_CH-1:0]         dn_valid,
  input  logic [N_CH-1:0]         dn_ready,
  output logic [N_CH*W-1:0]       dn_data,
  output logic                    err_sel,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int                SW     = sel_w(N_CH);
  localparam logic [MAX_SW:0]   NCH_V  = (MAX_SW+1)'(N_CH);

  logic [SW-1:0]     rr_cnt_q, rr_cnt_d;
  logic              err_sel_q, err_sel_d;
  drop_cnt_t         drop_cnt_q, drop_cnt_d;

  logic [SW-1:0]     w_tgt;
  logic [MAX_SW-1:0] w_tgt_ext;
  ch_vec_t           w_full_ext, w_rdy_ext;
  logic              w_in_range, w_accept, w_drop;
  logic [N_CH-1:0]   w_load;

  assign w_tgt = (AUTO_SEL != 0) ? rr_cnt_q : up_sel;

  // Widen target and flag vectors so out-of-range targets index safely.
  always_comb begin
    w_tgt_ext             = '0;
    w_tgt_ext[SW-1:0]     = w_tgt;
    w_full_ext            = '0;
    w_full_ext[N_CH-1:0]  = dn_valid;
    w_rdy_ext             = '0;
    w_rdy_ext[N_CH-1:0]   = dn_ready;
  end

  assign w_in_range = ({1'b0, w_tgt_ext} < NCH_V);
  assign up_ready   = ~w_in_range | ~w_full_ext[w_tgt_ext] | w_rdy_ext[w_tgt_ext];
  assign w_accept   = up_valid & up_ready;
  assign w_drop     = w_accept & ~w_in_range;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    assign w_load[k] = w_accept & w_in_range & (w_tgt_ext == MAX_SW'(k));

    demux_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (w_load[k]),
      .data_i  (up_data),
      .ready_i (dn_ready[k]),
      .valid_o (dn_valid[k]),
      .data_o  (dn_data[k*W +: W])
    );
  end

  // resync wins over the advance; the beat in that cycle used the old value.
  always_comb begin
    rr_cnt_d = rr_cnt_q;
    if (AUTO_SEL != 0) begin
      if (resync) begin
        rr_cnt_d = '0;
      end else if (w_accept) begin
        rr_cnt_d = (rr_cnt_q == SW'(N_CH-1)) ? '0 : rr_cnt_q + SW'(1);
      end
    end
  end

  always_comb begin
    err_sel_d  = w_drop;
    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_cnt_q   <= '0;
      err_sel_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rr_cnt_q   <= rr_cnt_d;
      err_sel_q  <= err_sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_sel  = err_sel_q;
  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ============================================================================
// tb_stream_demux
// Directed scoreboard bench: explicit-select, TDM and out-of-range instances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stream_demux;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] d;
  } exp_t;

  logic clk, rst_n;
  int   n_cmp, n_err;
  exp_t exp0[$];
  exp_t exp1[$];

  // Instance 0: N_CH=4, explicit select
  logic       v0, r0, rs0, err0;
  logic [7:0] d0, dc0;
  logic [1:0] s0;
  logic [3:0] dv0, dr0;
  logic [31:0] dd0;

  // Instance 1: N_CH=3, TDM
  logic       v1, r1, rs1, err1;
  logic [7:0] d1, dc1;
  logic [1:0] s1;
  logic [2:0] dv1, dr1;
  logic [23:0] dd1;

  // Instance 2: N_CH=3, explicit select, used for out-of-range drops
  logic       v2, r2, rs2, err2;
  logic [7:0] d2, dc2;
  logic [1:0] s2;
  logic [2:0] dv2, dr2;
  logic [23:0] dd2;

  stream_demux #(.N_CH(4), .W(8), .AUTO_SEL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .up_valid(v0), .up_ready(r0), .up_data(d0),
    .up_sel(s0), .resync(rs0), .dn_valid(dv0), .dn_ready(dr0), .dn_data(dd0),
    .err_sel(err0), .drop_cnt(dc0));

  stream_demux #(.N_CH(3), .W(8), .AUTO_SEL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .up_valid(v1), .up_ready(r1), .up_data(d1),
    .up_sel(s1), .resync(rs1), .dn_valid(dv1), .dn_ready(dr1), .dn_data(dd1),
    .err_sel(err1), .drop_cnt(dc1));

  stream_demux #(.N_CH(3), .W(8), .AUTO_SEL(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .up_valid(v2), .up_ready(r2), .up_data(d2),
    .up_sel(s2), .resync(rs2), .dn_valid(dv2), .dn_ready(dr2), .dn_data(dd2),
    .err_sel(err2), .drop_cnt(dc2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every downstream handshake (sampled on the falling edge).
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (dv0[k] && dr0[k]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < exp0.size(); j++)
            if (idx < 0 && exp0[j].ch == 4'(k)) idx = j;
          chk("u0_expected_beat", 32'(idx >= 0), 32'd1);
          if (idx >= 0) begin
            chk("u0_data", 32'(dd0[k*8 +: 8]), 32'(exp0[idx].d));
            exp0.delete(idx);
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (dv1[k] && dr1[k]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < exp1.size(); j++)
            if (idx < 0 && exp1[j].ch == 4'(k)) idx = j;
          chk("u1_expected_beat", 32'(idx >= 0), 32'd1);
          if (idx >= 0) begin
            chk("u1_data", 32'(dd1[k*8 +: 8]), 32'(exp1[idx].d));
            exp1.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr1, prev_ch;
    logic resync_now;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    v0 = 0; d0 = 0; s0 = 0; rs0 = 0; dr0 = 4'hF;
    v1 = 0; d1 = 0; s1 = 2'd3; rs1 = 0; dr1 = 3'h7;
    v2 = 0; d2 = 0; s2 = 0; rs2 = 0; dr2 = 3'h7;

    // Reset state
    @(posedge clk); @(negedge clk);
    chk("rst_up_ready", 32'(r0), 32'd1);
    chk("rst_dn_valid", 32'(dv0), 32'd0);
    chk("rst_dn_data", dd0, 32'd0);
    chk("rst_err_sel", 32'(err0), 32'd0);
    chk("rst_drop_cnt", 32'(dc0), 32'd0);
    #2 rst_n = 1'b1;

    // Basic routing: one beat per channel, each visible for exactly one cycle
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      v0 = (i < 4); s0 = 2'(i); d0 = 8'hA0 + 8'(i);
      @(negedge clk);
      chk("route_dn_valid", 32'(dv0), (i >= 1 && i <= 4) ? (32'd1 << (i-1)) : 32'd0);
      if (i < 4) begin
        chk("route_up_ready", 32'(r0), 32'd1);
        if (r0) exp0.push_back('{ch: 4'(i), d: d0});
      end
    end

    // Backpressure on channel 2
    @(posedge clk); #1;
    dr0 = 4'b1011; v0 = 1; s0 = 2'd2; d0 = 8'h11;
    @(negedge clk);
    chk("bp_first_ready", 32'(r0), 32'd1);
    if (r0) exp0.push_back('{ch: 4'd2, d: d0});
    @(posedge clk); #1;
    d0 = 8'h22;
    @(negedge clk);
    chk("bp_second_stalled", 32'(r0), 32'd0);
    chk("bp_hold_data", 32'(dd0[23:16]), 32'h11);
    @(posedge clk); #1;
    s0 = 2'd1; d0 = 8'h33;
    @(negedge clk);
    chk("bp_other_ch_ready", 32'(r0), 32'd1);
    chk("bp_hold_data2", 32'(dd0[23:16]), 32'h11);
    if (r0) exp0.push_back('{ch: 4'd1, d: d0});
    @(posedge clk); #1;
    s0 = 2'd2; d0 = 8'h22; dr0 = 4'hF;
    @(negedge clk);
    chk("bp_drain_load_ready", 32'(r0), 32'd1);
    if (r0) exp0.push_back('{ch: 4'd2, d: d0});
    @(posedge clk); #1;
    v0 = 0;
    @(negedge clk);
    chk("bp_no_gap", 32'(dv0), 32'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_empty", 32'(dv0), 32'd0);

    // Full throughput on channel 0
    for (int i = 0; i <= 16; i++) begin
      @(posedge clk); #1;
      v0 = (i < 16); s0 = 2'd0; d0 = 8'h40 + 8'(i);
      @(negedge clk);
      if (i >= 1) chk("tput_dn_valid", 32'(dv0[0]), 32'd1);
      if (i < 16) begin
        chk("tput_up_ready", 32'(r0), 32'd1);
        if (r0) exp0.push_back('{ch: 4'd0, d: d0});
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("tput_done", 32'(dv0), 32'd0);

    // TDM: 7 beats rotate 0,1,2,0,1,2,0 regardless of up_sel
    rr1 = 0; prev_ch = -1;
    for (int i = 0; i <= 7; i++) begin
      @(posedge clk); #1;
      v1 = (i < 7); d1 = 8'hB0 + 8'(i);
      @(negedge clk);
      chk("tdm_dn_valid", 32'(dv1), (prev_ch >= 0) ? (32'd1 << prev_ch) : 32'd0);
      prev_ch = -1;
      if (i < 7) begin
        chk("tdm_up_ready", 32'(r1), 32'd1);
        if (r1) begin
          exp1.push_back('{ch: 4'(rr1), d: d1});
          prev_ch = rr1;
          rr1 = (rr1 + 1) % 3;
        end
      end
    end

    // Idle resync, then resync together with beat 3
    @(posedge clk); #1;
    v1 = 0; rs1 = 1;
    rr1 = 0;
    prev_ch = -1;
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      resync_now = (i == 3);
      v1 = (i < 5); rs1 = resync_now; d1 = 8'hC0 + 8'(i);
      @(negedge clk);
      chk("resync_dn_valid", 32'(dv1), (prev_ch >= 0) ? (32'd1 << prev_ch) : 32'd0);
      prev_ch = -1;
      if (i < 5) begin
        chk("resync_up_ready", 32'(r1), 32'd1);
        if (r1) begin
          exp1.push_back('{ch: 4'(rr1), d: d1});
          prev_ch = rr1;
          rr1 = resync_now ? 0 : (rr1 + 1) % 3;
        end
      end
    end
    rs1 = 0; v1 = 0;

    // Out-of-range select: every beat accepted and dropped, counter saturates
    for (int i = 0; i <= 301; i++) begin
      @(posedge clk); #1;
      v2 = (i < 300); s2 = 2'd3; d2 = 8'(i);
      @(negedge clk);
      chk("oor_dn_valid", 32'(dv2), 32'd0);
      chk("oor_err_sel", 32'(err2), 32'(i >= 1 && i <= 300));
      chk("oor_drop_cnt", 32'(dc2), (i > 255) ? 32'd255 : 32'(i));
      if (i < 300) chk("oor_up_ready", 32'(r2), 32'd1);
    end
    v2 = 0;

    // Mid-stream asynchronous reset with channels 0 and 1 full
    @(posedge clk); #1;
    dr0 = 4'b1100; v0 = 1; s0 = 2'd0; d0 = 8'h55;
    @(posedge clk); #1;
    s0 = 2'd1; d0 = 8'h66;
    @(posedge clk); #1;
    v0 = 0;
    @(negedge clk);
    chk("mid_full", 32'(dv0), 32'b0011);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dn_valid", 32'(dv0), 32'd0);
    chk("mid_rst_dn_data", dd0, 32'd0);
    chk("mid_rst_up_ready", 32'(r0), 32'd1);
    exp0.delete();
    exp1.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    dr0 = 4'hF; v0 = 1; s0 = 2'd3; d0 = 8'h77;
    @(negedge clk);
    chk("post_rst_up_ready", 32'(r0), 32'd1);
    if (r0) exp0.push_back('{ch: 4'd3, d: d0});
    @(posedge clk); #1;
    v0 = 0;
    @(negedge clk);
    chk("post_rst_dn_valid", 32'(dv0), 32'b1000);
    @(posedge clk); #1;
    @(negedge clk);

    chk("u0_scoreboard_empty", 32'(exp0.size()), 32'd0);
    chk("u1_scoreboard_empty", 32'(exp1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
